time_set_controller: RTL and testbench

Pushbutton front end that lets the user edit four BCD digits (HH:MM) and commits them to the alarm clock core as either the current time or the alarm time. It drives the core's `hour_in1/hour_in0/minute_in1/minute_in0` and `load_time`/`load_alarm` inputs. Each load strobe is held long enough to be sampled by the core's 1-second domain. It sits between the board buttons and the alarm clock core, on the same 100 MHz clock.

---
 rtl/time_set_controller_if.sv | 40 ++++
 rtl/time_set_controller.sv | 169 ++++++++++++++++
 tb/tb_time_set_controller.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_if.sv
// time_set_controller_if
//   Bundles the pushbutton inputs and the BCD digit / load-strobe outputs
//   that pass between the board front end and the time_set_controller.
//   master : board / testbench side (drives buttons, observes outputs)
//   slave  : controller side (samples buttons, drives digits and strobes)
//   Signals:
//     btn_mode, btn_inc, btn_next, btn_enter : raw, unsynchronized buttons
//     hour_in1[1:0], hour_in0[3:0]            : hour tens / units (BCD)
//     minute_in1[3:0], minute_in0[3:0]        : minute tens / units (BCD)
//     load_time, load_alarm                   : load strobes to the core
//     edit_active                             : high while editing
//     edit_digit[1:0]                         : cursor position
//     busy                                    : high while a load is held
interface time_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_enter;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0;
  logic [3:0] minute_in1;
  logic [3:0] minute_in0;
  logic       load_time;
  logic       load_alarm;
  logic       edit_active;
  logic [1:0] edit_digit;
  logic       busy;

  modport master (
    output btn_mode, btn_inc, btn_next, btn_enter,
    input  hour_in1, hour_in0, minute_in1, minute_in0,
    input  load_time, load_alarm, edit_active, edit_digit, busy
  );

  modport slave (
    input  btn_mode, btn_inc, btn_next, btn_enter,
    output hour_in1, hour_in0, minute_in1, minute_in0,
    output load_time, load_alarm, edit_active, edit_digit, busy
  );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller
//   Pushbutton front end for editing HH:MM (four BCD digits) and committing
//   them to the alarm clock core as either the current time or the alarm.
//   Each button is synchronized, debounced and turned into a one-cycle press
//   event; a small FSM (IDLE / EDIT_TIME / EDIT_ALARM / LOAD) consumes the
//   events and holds the selected load strobe for LOAD_HOLD_CYCLES cycles.
//   Ports:
//     clock : system clock (100 MHz)
//     reset : asynchronous, active-high reset
//     bus   : time_set_controller_if.slave (buttons in, digits/strobes out)
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned LOAD_HOLD_CYCLES = 120_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  time_set_controller_if.slave  bus
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LDW = $clog2(LOAD_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT_TIME,
    S_EDIT_ALARM,
    S_LOAD
  } state_t;

  // Button bit order: [0]=mode [1]=inc [2]=next [3]=enter
  logic [3:0]     w_raw;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_db;
  logic [3:0]     r_db_q;
  logic [3:0]     r_press;
  logic [DBW-1:0] r_cnt [4];

  state_t         r_state;
  state_t         w_state_nx;
  logic [LDW-1:0] r_hold;
  logic           r_target_alarm;
  logic [1:0]     r_cursor;
  logic [1:0]     r_h1;
  logic [3:0]     r_h0;
  logic [3:0]     r_m1;
  logic [3:0]     r_m0;

  logic           w_ev_enter;
  logic           w_ev_mode;
  logic           w_ev_next;
  logic           w_ev_inc;
  logic           w_edit;
  logic           w_hold_done;
  logic [3:0]     w_h0_max;

  assign w_raw = {bus.btn_enter, bus.btn_next, bus.btn_inc, bus.btn_mode};

  // Synchronizer, per-button debounce counter, and registered rising-edge
  // pulse of the debounced level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Only the highest-priority press acts: enter > mode > next > inc.
  assign w_ev_enter = r_press[3];
  assign w_ev_mode  = r_press[0] & ~r_press[3];
  assign w_ev_next  = r_press[2] & ~r_press[3] & ~r_press[0];
  assign w_ev_inc   = r_press[1] & ~r_press[3] & ~r_press[0] & ~r_press[2];

  assign w_edit      = (r_state == S_EDIT_TIME) || (r_state == S_EDIT_ALARM);
  assign w_hold_done = (r_state == S_LOAD) && (r_hold == LDW'(LOAD_HOLD_CYCLES - 1));
  assign w_h0_max    = (r_h1 == 2'd2) ? 4'd3 : 4'd9;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:       if (w_ev_mode) w_state_nx = S_EDIT_TIME;
      S_EDIT_TIME:  if (w_ev_enter)     w_state_nx = S_LOAD;
                    else if (w_ev_mode) w_state_nx = S_EDIT_ALARM;
      S_EDIT_ALARM: if (w_ev_enter)     w_state_nx = S_LOAD;
                    else if (w_ev_mode) w_state_nx = S_IDLE;
      S_LOAD:       if (w_hold_done) w_state_nx = S_IDLE;
      default:      w_state_nx = S_IDLE;
    endcase
  end

  // Hold counter, load target, cursor and digit registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold         <= '0;
      r_target_alarm <= 1'b0;
      r_cursor       <= '0;
      r_h1           <= '0;
      r_h0           <= '0;
      r_m1           <= '0;
      r_m0           <= '0;
    end else begin
      if (r_state == S_LOAD) r_hold <= r_hold + 1'b1;
      else                   r_hold <= '0;

      if (w_edit && w_ev_enter) r_target_alarm <= (r_state == S_EDIT_ALARM);

      if (w_ev_mode && (r_state == S_IDLE || r_state == S_EDIT_TIME))
        r_cursor <= '0;
      else if (w_edit && w_ev_next)
        r_cursor <= r_cursor + 2'd1;

      if (w_edit && w_ev_inc) begin
        case (r_cursor)
          2'd0: begin
            r_h1 <= (r_h1 >= 2'd2) ? 2'd0 : r_h1 + 2'd1;
            // Stepping the tens to 2 must not leave the hour above 23.
            if (r_h1 == 2'd1 && r_h0 > 4'd3) r_h0 <= 4'd3;
          end
          2'd1:    r_h0 <= (r_h0 >= w_h0_max) ? 4'd0 : r_h0 + 4'd1;
          2'd2:    r_m1 <= (r_m1 >= 4'd5)     ? 4'd0 : r_m1 + 4'd1;
          default: r_m0 <= (r_m0 >= 4'd9)     ? 4'd0 : r_m0 + 4'd1;
        endcase
      end
    end
  end

  // FSM outputs; strobes decode from the async-reset state so they drop
  // immediately on reset.
  always_comb begin
    bus.load_time   = (r_state == S_LOAD) && !r_target_alarm;
    bus.load_alarm  = (r_state == S_LOAD) &&  r_target_alarm;
    bus.busy        = (r_state == S_LOAD);
    bus.edit_active = w_edit;
    bus.edit_digit  = r_cursor;
    bus.hour_in1    = r_h1;
    bus.hour_in0    = r_h0;
    bus.minute_in1  = r_m1;
    bus.minute_in0  = r_m0;
  end

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller
//   Scoreboard bench: stimulus issues button presses and a behavioural model
//   pushes every expected visible output change (with its cycle) into a
//   queue; an independent monitor pops and compares whenever the DUT
//   outputs change.
module tb_time_set_controller;
  localparam int unsigned D = 4;
  localparam int unsigned L = 8;
  localparam int LAT = 8;  // drive-to-update: 2 sync + D + pulse + update

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  time_set_controller_if bus ();

  time_set_controller #(
    .DEBOUNCE_CYCLES (D),
    .LOAD_HOLD_CYCLES(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic       lt;
    logic       la;
    logic       ea;
    logic [1:0] cur;
    logic       busy;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;
  snap_t mon_last;

  // Model: mode 0 idle, 1 editing time, 2 editing alarm, 3 loading
  int    md_mode;
  int    md_tgt;
  int    dg[4];
  int    md_cur;
  int    load_end;
  snap_t last_exp;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic snap_t dut_snap();
    snap_t s;
    s.h1 = bus.hour_in1;    s.h0 = bus.hour_in0;
    s.m1 = bus.minute_in1;  s.m0 = bus.minute_in0;
    s.lt = bus.load_time;   s.la = bus.load_alarm;
    s.ea = bus.edit_active; s.cur = bus.edit_digit;
    s.busy = bus.busy;
    return s;
  endfunction

  function automatic snap_t mk_snap(int mode, int tgt);
    snap_t s;
    s.h1 = 2'(dg[0]); s.h0 = 4'(dg[1]); s.m1 = 4'(dg[2]); s.m0 = 4'(dg[3]);
    s.lt = (mode == 3 && tgt == 1);
    s.la = (mode == 3 && tgt == 2);
    s.ea = (mode == 1 || mode == 2);
    s.cur = 2'(md_cur);
    s.busy = (mode == 3);
    return s;
  endfunction

  task automatic model_reset();
    md_mode = 0; md_tgt = 0; md_cur = 0; load_end = 0;
    for (int i = 0; i < 4; i++) dg[i] = 0;
    last_exp = '0;
  endtask

  task automatic push(snap_t s, int e);
    exp_t x;
    x.s = s; x.cyc = e;
    sb.push_back(x);
  endtask

  // Press event m (bit0 mode, bit1 inc, bit2 next, bit3 enter) acting on edge e
  task automatic model_event(bit [3:0] m, int e);
    snap_t s;
    int    lim;
    if (md_mode == 3 && e > load_end) md_mode = 0;
    if (md_mode == 3) return;
    if (m[3]) begin
      if (md_mode != 0) begin
        md_tgt = md_mode;
        md_mode = 3;
        load_end = e + L;
        push(mk_snap(3, md_tgt), e);
        last_exp = mk_snap(0, md_tgt);
        push(last_exp, load_end);
      end
      return;
    end else if (m[0]) begin
      if (md_mode == 0)      begin md_mode = 1; md_cur = 0; end
      else if (md_mode == 1) begin md_mode = 2; md_cur = 0; end
      else                   md_mode = 0;
    end else if (m[2]) begin
      if (md_mode != 0) md_cur = (md_cur + 1) % 4;
    end else if (m[1]) begin
      if (md_mode != 0) begin
        case (md_cur)
          0: lim = 2;
          1: lim = (dg[0] == 2) ? 3 : 9;
          2: lim = 5;
          default: lim = 9;
        endcase
        dg[md_cur] = (dg[md_cur] == lim) ? 0 : dg[md_cur] + 1;
        if (md_cur == 0 && dg[0] == 2 && dg[1] > 3) dg[1] = 3;
      end
    end
    s = mk_snap(md_mode, md_tgt);
    if (s != last_exp) begin
      push(s, e);
      last_exp = s;
    end
  endtask

  task automatic set_btns(bit [3:0] m, logic v);
    if (m[0]) bus.btn_mode  = v;
    if (m[1]) bus.btn_inc   = v;
    if (m[2]) bus.btn_next  = v;
    if (m[3]) bus.btn_enter = v;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called just after a posedge; holds the buttons for 'hold' cycles.
  task automatic press(bit [3:0] m, int hold, int gap);
    int k;
    k = cyc;
    set_btns(m, 1'b1);
    if (hold >= int'(D)) model_event(m, k + LAT);
    tick(hold);
    set_btns(m, 1'b0);
    tick(gap);
  endtask

  task automatic press_n(bit [3:0] m, int n);
    repeat (n) press(m, 5, 10);
  endtask

  always @(negedge clock) begin
    snap_t c;
    exp_t  x;
    c = dut_snap();
    if (!mon_en) begin
      mon_last = c;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        x = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_change: actual snap=%h (no change), required snap=%h at cyc %0d",
                 c, x.s, x.cyc);
      end
      if (c !== mon_last) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: actual snap=%h at cyc %0d, required no change from %h",
                   c, cyc, mon_last);
        end else begin
          x = sb.pop_front();
          if (c !== x.s || cyc != x.cyc) begin
            miscompares++;
            $display("FAIL output_change: actual snap=%h cyc=%0d, required snap=%h cyc=%0d",
                     c, cyc, x.s, x.cyc);
          end
        end
        mon_last = c;
      end
    end
  end

  initial begin
    int    k;
    int    r;
    int    guard;
    bit [3:0] m;
    snap_t c;

    reset = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    bus.btn_next = 1'b0; bus.btn_enter = 1'b0;
    model_reset();
    tick(3);
    reset = 1'b0;
    c = dut_snap();
    vectors++;
    if (c !== '0) begin
      miscompares++;
      $display("FAIL reset_state: actual snap=%h, required snap=0", c);
    end
    mon_en = 1'b1;
    tick(2);

    // Debounce: 3-cycle bounce is no event, 10-cycle hold is one event
    press(4'b0001, 5, 10);     // IDLE -> EDIT_TIME
    press(4'b0010, 3, 12);     // bounce on inc, ignored
    press(4'b0010, 10, 12);    // h1 0 -> 1

    // Time load 2,3,5,9
    press_n(4'b0010, 1);       // h1 = 2
    press_n(4'b0100, 1);
    press_n(4'b0010, 3);       // h0 = 3
    press_n(4'b0100, 1);
    press_n(4'b0010, 5);       // m1 = 5
    press_n(4'b0100, 1);
    press_n(4'b0010, 9);       // m0 = 9
    press(4'b1000, 5, 14);     // load_time for L cycles

    // Clamp and wrap
    press_n(4'b0001, 1);       // EDIT_TIME, cursor 0
    press_n(4'b0010, 1);       // h1 2 -> 0
    press_n(4'b0100, 1);
    press_n(4'b0010, 4);       // h0 3 -> 7
    press_n(4'b0100, 3);       // cursor back to 0
    press_n(4'b0010, 2);       // h1 -> 2, h0 clamps to 3
    press_n(4'b0100, 1);
    press_n(4'b0010, 1);       // h0 3 -> 0
    press_n(4'b0100, 1);
    press_n(4'b0010, 6);       // m1 full lap

    // Alarm path and cancel
    press_n(4'b0001, 2);       // -> EDIT_ALARM -> IDLE
    press_n(4'b0001, 2);       // -> EDIT_TIME -> EDIT_ALARM
    press(4'b1000, 5, 14);     // load_alarm
    press_n(4'b0001, 3);       // cancel round trip

    // Priority and LOAD discard
    press_n(4'b0001, 1);
    fork
      press(4'b1010, 5, 14);
      begin
        tick(2);
        press(4'b0001, 5, 14);
      end
    join
    press_n(4'b0010, 1);       // IDLE: ignored

    // Reset on the 4th LOAD cycle
    press_n(4'b0001, 1);
    k = cyc;
    set_btns(4'b1000, 1'b1);
    model_event(4'b1000, k + LAT);
    tick(5);
    set_btns(4'b1000, 1'b0);
    while (cyc < k + LAT + 3) tick(1);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    c = dut_snap();
    vectors++;
    if (c !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_load: actual snap=%h, required snap=0", c);
    end
    sb.delete();
    model_reset();
    tick(2);
    reset = 1'b0;
    mon_en = 1'b1;
    tick(2);
    press_n(4'b0110, 1);       // IDLE: ignored
    press_n(4'b0001, 1);       // IDLE -> EDIT_TIME

    // Randomized presses
    repeat (80) begin
      r = $urandom_range(0, 15);
      if (r < 3)       m = 4'b0001;
      else if (r < 8)  m = 4'b0010;
      else if (r < 11) m = 4'b0100;
      else if (r < 13) m = 4'b1000;
      else             m = 4'($urandom_range(1, 15));
      press(m, $urandom_range(2, 7), $urandom_range(8, 16));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    tick(2);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d expected changes still pending, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
